// File: rtl/ifu_pkg.sv
// Shared types and instruction field layout for the instruction fetch unit.
// The optional fetch timeout is enabled with IFU_TIMEOUT_EN.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } ifu_state_e;

  localparam logic [1:0] TYPE_ALU  = 2'b00;
  localparam logic [1:0] TYPE_MEM  = 2'b01;
  localparam logic [1:0] TYPE_CTL  = 2'b10;
  localparam logic [1:0] TYPE_HALT = 2'b11;

  localparam logic [4:0] OP_JUMP   = 5'b10010;
  localparam logic [4:0] OP_BRANCH = 5'b10011;

  // Field positions assume a 16-bit instruction word.
  localparam int TYPE_HI = 15;
  localparam int TYPE_LO = 14;
  localparam int OP_HI   = 13;
  localparam int OP_LO   = 9;
  localparam int TGT_HI  = 8;
  localparam int TGT_LO  = 3;

endpackage

// File: rtl/ifu_next_pc.sv
// Combinational next-PC selector: sequential, jump, branch on alu_bool, or halt.
module ifu_next_pc
  import ifu_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int INSTR_W = 16
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               alu_bool,
  output logic [ADDR_W-1:0]  next_pc,
  output logic               is_halt
);

  logic [1:0]        typ;
  logic [4:0]        op;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] seq_pc;
  logic              unused_lo;

  assign typ       = instr[TYPE_HI:TYPE_LO];
  assign op        = instr[OP_HI:OP_LO];
  assign tgt       = ADDR_W'(instr[TGT_HI:TGT_LO]);
  assign seq_pc    = pc + ADDR_W'(1);
  assign unused_lo = ^instr[TGT_LO-1:0];

  always_comb begin
    next_pc = seq_pc;
    is_halt = 1'b0;
    case (typ)
      TYPE_CTL: begin
        if (op == OP_JUMP || (op == OP_BRANCH && alu_bool)) next_pc = tgt;
      end
      TYPE_HALT: begin
        next_pc = pc;
        is_halt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches over req/rvalid, issues one word at a time.
// Define IFU_TIMEOUT_EN to add a WAIT-state timeout that sets a sticky fetch_err and halts.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int INSTR_W = 16
`ifdef IFU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 15
`endif
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  input  logic               alu_bool,
  input  logic               resume,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               fetch_err
);

  ifu_state_e         state, state_nxt;
  logic [ADDR_W-1:0]  pc_nxt;
  logic [ADDR_W-1:0]  issue_pc;
  logic [INSTR_W-1:0] instr_nxt;
  logic               issue_halt;
  logic               tmo_hit;

  ifu_next_pc #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_next_pc (
    .instr    (instr_out),
    .pc       (pc),
    .alu_bool (alu_bool),
    .next_pc  (issue_pc),
    .is_halt  (issue_halt)
  );

`ifdef IFU_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  // Fires on the last allowed WAIT cycle when the response still has not arrived.
  assign tmo_hit = (state == S_WAIT) && !imem_rvalid &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (state == S_WAIT && state_nxt == S_WAIT) ? tmo_cnt + 1'b1 : '0;
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  assign tmo_hit   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr_out;
    case (state)
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (tmo_hit) begin
          state_nxt = S_HALT;
        end else if (imem_rvalid) begin
          instr_nxt = imem_rdata;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        pc_nxt    = issue_pc;
        state_nxt = issue_halt ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (resume) begin
          pc_nxt    = pc + ADDR_W'(1);
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= '0;
      instr_out <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      instr_out <= instr_nxt;
    end
  end

  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_ISSUE);
  assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle instruction memory model.
// Timeout checks follow IFU_TIMEOUT_EN when it is defined for the build.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        imem_rvalid = 1'b0;
  logic        alu_bool = 1'b0;
  logic        resume = 1'b0;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic [5:0]  pc;
  logic        halted;
  logic        fetch_err;

  logic [15:0] mem [64];
  logic        mem_hold = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .alu_bool    (alu_bool),
    .resume      (resume),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted),
    .fetch_err   (fetch_err)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory answers a request seen in one cycle with rvalid during the next.
  initial begin
    logic       pend;
    logic [5:0] paddr;
    forever begin
      @(negedge clk);
      pend  = imem_req && !mem_hold;
      paddr = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = pend && !rst;
      imem_rdata  = pend ? mem[paddr] : 16'h0000;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 16'h0000;
  endtask

  // Leaves the bench at the negedge where the DUT sits in FETCH for pc 0.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic next_fetch(output logic [5:0] a);
    int n = 0;
    a = 6'h3f;
    do begin
      @(negedge clk);
      n++;
    end while (!imem_req && n < 50);
    if (imem_req) a = imem_addr;
    else begin
      n_chk++;
      $display("FAIL fetch_wait: no imem_req within %0d cycles", n);
    end
  endtask

  task automatic wait_issue(output int t);
    int n = 0;
    t = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 50);
    if (instr_valid) t = cyc;
    else begin
      n_chk++;
      $display("FAIL issue_wait: no instr_valid within %0d cycles", n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] a;
    int t1, t2, nreq, nhalt;

    // sequential fetch, issue spacing, jump
    clear_mem();
    mem[1]  = 16'h4000;
    mem[3]  = 16'hA4A8;
    mem[21] = 16'hC000;
    do_reset();
    chk("rst_req", imem_req, 1);
    chk("rst_addr", imem_addr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", fetch_err, 0);
    wait_issue(t1);
    chk("issue0_instr", instr_out, 16'h0000);
    next_fetch(a);
    chk("fetch1_addr", a, 1);
    wait_issue(t2);
    chk("issue_spacing", t2 - t1, 3);
    chk("issue1_instr", instr_out, 16'h4000);
    next_fetch(a);
    chk("pc_after_issue1", pc, 2);
    next_fetch(a);
    chk("fetch3_addr", a, 3);
    next_fetch(a);
    chk("jump_addr", a, 21);

    // branch taken / not taken
    clear_mem();
    mem[5] = 16'hA6A8;
    alu_bool = 1'b1;
    do_reset();
    repeat (5) next_fetch(a);
    chk("br_fetch5", a, 5);
    next_fetch(a);
    chk("br_taken", a, 21);
    alu_bool = 1'b0;
    do_reset();
    repeat (6) next_fetch(a);
    chk("br_not_taken", a, 6);

    // jump to 63, then sequential wrap to 0
    clear_mem();
    mem[0] = 16'hA5F8;
    do_reset();
    next_fetch(a);
    chk("jump_63", a, 63);
    next_fetch(a);
    chk("pc_wrap", a, 0);

    // halt, resume, resume ignored in WAIT
    clear_mem();
    mem[7] = 16'hC000;
    do_reset();
    repeat (7) next_fetch(a);
    chk("halt_fetch7", a, 7);
    wait_issue(t1);
    nreq = 0;
    nhalt = 0;
    repeat (10) begin
      @(negedge clk);
      nreq += int'(imem_req);
      nhalt += int'(halted);
    end
    chk("halt_no_req", nreq, 0);
    chk("halt_cycles", nhalt, 10);
    chk("halt_pc", pc, 7);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, 8);
    @(negedge clk);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    chk("resume_wait_issue", instr_valid, 1);
    chk("resume_wait_pc", pc, 8);
    next_fetch(a);
    chk("after_wait_resume", a, 9);
    chk("after_wait_halted", halted, 0);

    // memory never answers
    clear_mem();
    mem_hold = 1'b1;
    do_reset();
`ifdef IFU_TIMEOUT_EN
    repeat (15) @(negedge clk);
    chk("tmo_not_yet", halted, 0);
    @(negedge clk);
    chk("tmo_halted", halted, 1);
    chk("tmo_err", fetch_err, 1);
    chk("tmo_pc", pc, 0);
    mem_hold = 1'b0;
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    chk("tmo_refetch_req", imem_req, 1);
    chk("tmo_refetch_addr", imem_addr, 1);
    chk("tmo_err_sticky", fetch_err, 1);
`else
    nreq = 0;
    nhalt = 0;
    repeat (100) begin
      @(negedge clk);
      nreq += int'(imem_req);
      nhalt += int'(halted);
    end
    chk("hold_no_req", nreq, 0);
    chk("hold_no_halt", nhalt, 0);
    chk("hold_err", fetch_err, 0);
    chk("hold_pc", pc, 0);
    mem_hold = 1'b0;
`endif

    // reset while waiting on a response
    clear_mem();
    mem[0]  = 16'hA460;
    mem[12] = 16'h1234;
    do_reset();
    next_fetch(a);
    chk("mid_fetch12", a, 12);
    @(negedge clk);
    chk("mid_wait_pc", pc, 12);
    chk("mid_wait_instr", instr_out, 16'hA460);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_req", imem_req, 1);
    chk("mid_rst_addr", imem_addr, 0);
    chk("mid_rst_instr", instr_out, 0);
    chk("mid_rst_valid", instr_valid, 0);
    wait_issue(t1);
    chk("mid_rst_refetch", instr_out, 16'hA460);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
